// File: rtl/axi_write_burst_slave_if.sv
// AXI3 write-channel bundle (AW, W, B) shared by the burst slave and its master.
// The slave modport is the endpoint side; master drives requests and data.
`timescale 1ns/1ps
interface axi_write_burst_slave_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) ();
    logic [ID_W-1:0]     AWID;
    logic [ADDR_W-1:0]   AWADDR;
    logic [3:0]          AWLEN;
    logic [2:0]          AWSIZE;
    logic [1:0]          AWBURST;
    logic [1:0]          AWLOCK;
    logic [3:0]          AWCACHE;
    logic [2:0]          AWPROT;
    logic                AWVALID;
    logic                AWREADY;
    logic [ID_W-1:0]     WID;
    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WLAST;
    logic                WVALID;
    logic                WREADY;
    logic [ID_W-1:0]     BID;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWVALID,
        output AWREADY,
        input  WID, WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY
    );

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWVALID,
        input  AWREADY,
        output WID, WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY
    );
endinterface

// File: rtl/axi_write_burst_slave.sv
// AXI3 write slave: one burst at a time, FIXED/INCR/WRAP with narrow lanes,
// each accepted W beat is forwarded as a byte-enabled memory write, one B per burst.
`timescale 1ns/1ps
module axi_write_burst_slave #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    axi_write_burst_slave_if.slave axi,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    input  logic                mem_ready_i,
    output logic                busy_o
);
    localparam int STRB_W = DATA_W / 8;
    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [3:0]        len_q, len_d;
    logic [3:0]        beat_cnt_q, beat_cnt_d;
    logic [2:0]        size_q, size_d;
    logic [1:0]        burst_q, burst_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] beat_bytes, wrap_total, wrap_base, wrap_next, incr_next, next_addr;
    logic [ADDR_W-1:0] lane_lo, lane_hi;
    logic [STRB_W-1:0] lane_mask;
    logic [31:0]       aw_bytes;
    logic              aw_err, aw_wrap, beat_acc, last_beat;

    assign beat_bytes = ONE << size_q;
    assign wrap_total = beat_bytes * ADDR_W'({1'b0, len_q} + 5'd1);
    assign wrap_base  = cur_addr_q & ~(wrap_total - ONE);
    assign wrap_next  = wrap_base + ((cur_addr_q + beat_bytes - wrap_base) & (wrap_total - ONE));
    assign incr_next  = (cur_addr_q & ~(beat_bytes - ONE)) + beat_bytes;

    always_comb begin
        case (burst_q)
            2'b00:   next_addr = cur_addr_q;
            2'b10:   next_addr = wrap_next;
            default: next_addr = incr_next;
        endcase
    end

    // Active lanes: from the address offset up to the end of the size-aligned container.
    assign lane_lo = cur_addr_q & ADDR_W'(STRB_W - 1);
    assign lane_hi = (lane_lo & ~(beat_bytes - ONE)) + beat_bytes - ONE;

    generate
        for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
            assign lane_mask[gi] = (ADDR_W'(gi) >= lane_lo) && (ADDR_W'(gi) <= lane_hi);
        end
    endgenerate

    assign aw_bytes = 32'd1 << axi.AWSIZE;
    assign aw_wrap  = (axi.AWBURST == 2'b10);
    assign aw_err   = (aw_bytes > 32'(STRB_W))
                   || (axi.AWBURST == 2'b11)
                   || (aw_wrap && !(axi.AWLEN inside {4'd1, 4'd3, 4'd7, 4'd15}))
                   || (aw_wrap && ((axi.AWADDR & ADDR_W'(aw_bytes - 32'd1)) != '0));

    assign axi.AWREADY = (state_q == IDLE) && rst_ni;
    assign axi.WREADY  = (state_q == DATA) && mem_ready_i;
    assign axi.BVALID  = (state_q == RESP);
    assign axi.BID     = id_q;
    assign axi.BRESP   = ((state_q == RESP) && err_q) ? 2'b10 : 2'b00;

    assign beat_acc    = axi.WREADY && axi.WVALID;
    assign last_beat   = (beat_cnt_q == len_q);
    assign mem_we_o    = beat_acc && !err_q;
    assign mem_addr_o  = cur_addr_q;
    assign mem_wdata_o = axi.WDATA;
    assign mem_be_o    = (state_q == DATA) ? (axi.WSTRB & lane_mask) : '0;
    assign busy_o      = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        len_d      = len_q;
        size_d     = size_q;
        burst_d    = burst_q;
        cur_addr_d = cur_addr_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (axi.AWVALID) begin
                    id_d       = axi.AWID;
                    len_d      = axi.AWLEN;
                    size_d     = axi.AWSIZE;
                    burst_d    = axi.AWBURST;
                    cur_addr_d = axi.AWADDR;
                    beat_cnt_d = '0;
                    err_d      = aw_err;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (beat_acc) begin
                    if ((axi.WID != id_q) || (axi.WLAST != last_beat)) err_d = 1'b1;
                    cur_addr_d = next_addr;
                    beat_cnt_d = beat_cnt_q + 4'd1;
                    if (last_beat) state_d = RESP;
                end
            end
            RESP: begin
                if (axi.BREADY) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            id_q       <= '0;
            len_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            cur_addr_q <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            len_q      <= len_d;
            size_q     <= size_d;
            burst_q    <= burst_d;
            cur_addr_q <= cur_addr_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end
endmodule
